// File: rtl/fir_tdm_pkg.sv
// fir_tdm_pkg: shared defaults and FSM state encoding for the time-shared FIR scheduler.
// Provides parameter defaults (coefficient width, tap count, phases, multipliers,
// multiplier-to-accumulator latency) and the IDLE/RUN/DRAIN state enumeration.
package fir_tdm_pkg;
    localparam int DEF_WIDTH    = 18;
    localparam int DEF_NTAPS    = 51;
    localparam int DEF_PHASES   = 4;
    localparam int DEF_MULTS    = 13;
    localparam int DEF_PIPE_LAT = 4;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
endpackage

// File: rtl/fir_coef_bank.sv
// fir_coef_bank: double-buffered coefficient storage with a phase-indexed output mux.
// Ports:
//   sys_clk      - clock
//   i_we         - write strobe (already qualified: in range and accepted)
//   i_addr       - coefficient index to write
//   i_data       - coefficient value
//   i_bank_sel   - active bank; writes always target the other (shadow) bank
//   i_phase      - current time-share phase
//   o_coef_bus   - slice m = active[PHASES*m + phase], or 0 past the last tap
module fir_coef_bank
    import fir_tdm_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int NTAPS  = DEF_NTAPS,
    parameter int PHASES = DEF_PHASES,
    parameter int MULTS  = DEF_MULTS
) (
    input  logic                      sys_clk,
    input  logic                      i_we,
    input  logic [5:0]                i_addr,
    input  logic [WIDTH-1:0]          i_data,
    input  logic                      i_bank_sel,
    input  logic [$clog2(PHASES)-1:0] i_phase,
    output logic [MULTS*WIDTH-1:0]    o_coef_bus
);
    localparam int AW = $clog2(NTAPS);
    localparam int PW = $clog2(PHASES);

    // Contents are deliberately not reset; firmware reloads them.
    logic [WIDTH-1:0] r_mem [2][NTAPS];

    always_ff @(posedge sys_clk) begin
        if (i_we) r_mem[~i_bank_sel][AW'(i_addr)] <= i_data;
    end

    // Taps beyond NTAPS in the last multiplier's column read as zero.
    always_comb begin
        o_coef_bus = '0;
        for (int m = 0; m < MULTS; m++)
            for (int p = 0; p < PHASES; p++)
                if (PHASES*m + p < NTAPS && i_phase == PW'(p))
                    o_coef_bus[m*WIDTH +: WIDTH] = r_mem[i_bank_sel][AW'(PHASES*m + p)];
    end
endmodule

// File: rtl/fir_tdm_sched.sv
// fir_tdm_sched: phase sequencer, strobe generator and coefficient-bank swap control
// for a time-division-multiplexed symmetric FIR.
// Ports:
//   sys_clk, reset    - clock, synchronous active-high reset
//   i_run             - level request to stream samples
//   o_sam_clk_en      - one-cycle strobe on the last phase of each sample
//   o_phase           - current time-share phase
//   o_coef_bus        - per-multiplier coefficients for the current phase
//   o_acc_clr         - accumulator load strobe, PIPE_LAT after phase 0
//   o_y_valid         - complete output sample, PIPE_LAT+PHASES after phase 0
//   i_cfg_valid/o_cfg_ready/i_cfg_addr/i_cfg_data/i_cfg_commit - coefficient writes
//   o_cfg_err         - pulse one cycle after an out-of-range write
//   o_bank_sel        - active coefficient bank
module fir_tdm_sched
    import fir_tdm_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int NTAPS    = DEF_NTAPS,
    parameter int PHASES   = DEF_PHASES,
    parameter int MULTS    = DEF_MULTS,
    parameter int PIPE_LAT = DEF_PIPE_LAT
) (
    input  logic                      sys_clk,
    input  logic                      reset,
    input  logic                      i_run,
    output logic                      o_sam_clk_en,
    output logic [$clog2(PHASES)-1:0] o_phase,
    output logic [MULTS*WIDTH-1:0]    o_coef_bus,
    output logic                      o_acc_clr,
    output logic                      o_y_valid,
    input  logic                      i_cfg_valid,
    output logic                      o_cfg_ready,
    input  logic [5:0]                i_cfg_addr,
    input  logic [WIDTH-1:0]          i_cfg_data,
    input  logic                      i_cfg_commit,
    output logic                      o_cfg_err,
    output logic                      o_bank_sel
);
    localparam int PW  = $clog2(PHASES);
    localparam int SRL = PIPE_LAT + PHASES;

    state_t          r_state, w_state_nxt;
    logic [PW-1:0]   r_phase, w_phase_nxt;
    logic            w_last, w_p0;
    logic [SRL-1:0]  r_sr;
    logic            r_swap_pend, r_bank_sel, r_cfg_err;
    logic            w_acc, w_wr, w_oob;

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_phase <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
        end
    end

    // RUN and DRAIN share transitions: a drop of run only ends the stream
    // once the sample in flight reaches its last phase.
    always_comb begin
        w_last       = r_phase == PW'(PHASES-1);
        w_state_nxt  = r_state;
        w_phase_nxt  = '0;
        o_sam_clk_en = 1'b0;
        w_p0         = 1'b0;
        if (r_state != IDLE) begin
            w_phase_nxt  = w_last ? '0 : r_phase + 1'b1;
            o_sam_clk_en = w_last;
            w_p0         = r_phase == '0;
            w_state_nxt  = i_run ? RUN : (w_last ? IDLE : DRAIN);
        end else if (i_run) begin
            w_state_nxt = RUN;
        end
    end

    assign o_cfg_ready = ~r_swap_pend;
    assign w_acc       = i_cfg_valid && o_cfg_ready;
    assign w_wr        = w_acc && int'(i_cfg_addr) < NTAPS;
    assign w_oob       = w_acc && int'(i_cfg_addr) >= NTAPS;

    // One shift register carries each phase-0 mark to both acc_clr and y_valid,
    // so a pulse already launched survives leaving RUN and dies only on reset.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_sr        <= '0;
            r_swap_pend <= 1'b0;
            r_bank_sel  <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_sr      <= {r_sr[SRL-2:0], w_p0};
            r_cfg_err <= w_oob;
            // Swap only at a sample boundary (or immediately when idle) so one
            // sample never mixes coefficients from both banks.
            if (r_swap_pend && (r_state == IDLE || o_sam_clk_en)) begin
                r_bank_sel  <= ~r_bank_sel;
                r_swap_pend <= 1'b0;
            end else if (i_cfg_commit && o_cfg_ready) begin
                r_swap_pend <= 1'b1;
            end
        end
    end

    assign o_phase    = r_phase;
    assign o_acc_clr  = r_sr[PIPE_LAT-1];
    assign o_y_valid  = r_sr[SRL-1];
    assign o_cfg_err  = r_cfg_err;
    assign o_bank_sel = r_bank_sel;

    fir_coef_bank #(
        .WIDTH  (WIDTH),
        .NTAPS  (NTAPS),
        .PHASES (PHASES),
        .MULTS  (MULTS)
    ) u_bank (
        .sys_clk    (sys_clk),
        .i_we       (w_wr),
        .i_addr     (i_cfg_addr),
        .i_data     (i_cfg_data),
        .i_bank_sel (r_bank_sel),
        .i_phase    (r_phase),
        .o_coef_bus (o_coef_bus)
    );
endmodule

// File: tb/tb_fir_tdm_sched.sv
// tb_fir_tdm_sched: self-checking bench for fir_tdm_sched (sequencing, strobes,
// bank writes/swaps, error pulses and reset flush).
module tb_fir_tdm_sched;
    localparam int W  = 18;
    localparam int NT = 51;
    localparam int P  = 4;
    localparam int M  = 13;

    typedef struct {
        logic       run;
        logic [1:0] ph;
        logic       sam;
        logic       clr;
        logic       yv;
    } vec_t;

    logic           sys_clk = 1'b0;
    logic           reset = 1'b1;
    logic           run = 1'b0;
    logic           cfg_valid = 1'b0;
    logic           cfg_commit = 1'b0;
    logic [5:0]     cfg_addr = '0;
    logic [W-1:0]   cfg_data = '0;
    logic           sam, clr, yv, rdy, err, bsel;
    logic [1:0]     ph;
    logic [M*W-1:0] cbus;

    int             n_pass = 0;
    int             n_tot = 0;
    int             eb = 0;
    logic [W-1:0]   model [2][NT];
    int             err_q[$];
    vec_t           tbl[19];

    always #5 sys_clk = ~sys_clk;

    fir_tdm_sched dut (
        .sys_clk      (sys_clk),
        .reset        (reset),
        .i_run        (run),
        .o_sam_clk_en (sam),
        .o_phase      (ph),
        .o_coef_bus   (cbus),
        .o_acc_clr    (clr),
        .o_y_valid    (yv),
        .i_cfg_valid  (cfg_valid),
        .o_cfg_ready  (rdy),
        .i_cfg_addr   (cfg_addr),
        .i_cfg_data   (cfg_data),
        .i_cfg_commit (cfg_commit),
        .o_cfg_err    (err),
        .o_bank_sel   (bsel)
    );

    function automatic vec_t mk(input int r, input int p, input int s, input int c, input int y);
        vec_t v;
        v.run = r[0];
        v.ph  = p[1:0];
        v.sam = s[0];
        v.clr = c[0];
        v.yv  = y[0];
        return v;
    endfunction

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        else n_pass++;
    endtask

    task automatic wr(input int a, input int d);
        cfg_valid = 1'b1;
        cfg_addr  = 6'(a);
        cfg_data  = W'(d);
        err_q.push_back(a >= NT ? 1 : 0);
        if (a < NT) model[1-eb][a] = W'(d);
        step();
        cfg_valid = 1'b0;
        chk("cfg_err", int'(err), err_q.pop_front());
    endtask

    task automatic commit_idle();
        cfg_commit = 1'b1;
        step();
        cfg_commit = 1'b0;
        chk("pend_ready", int'(rdy), 0);
        chk("pend_bank", int'(bsel), eb);
        step();
        eb = 1 - eb;
        chk("swap_bank", int'(bsel), eb);
        chk("swap_ready", int'(rdy), 1);
    endtask

    task automatic chk_coef(input int p);
        for (int m = 0; m < M; m++) begin
            int idx;
            idx = P*m + p;
            chk($sformatf("coef_p%0d_m%0d", p, m), int'(cbus[m*W +: W]),
                idx < NT ? int'(model[eb][idx]) : 0);
        end
    endtask

    task automatic run_sample();
        run = 1'b1;
        step();
        for (int p = 0; p < P; p++) begin
            chk("run_phase", int'(ph), p);
            chk_coef(p);
            if (p == P-1) run = 1'b0;
            step();
        end
        chk("idle_phase", int'(ph), 0);
    endtask

    initial begin
        tbl[0]  = mk(1, 0, 0, 0, 0);
        tbl[1]  = mk(1, 0, 0, 0, 0);
        tbl[2]  = mk(1, 1, 0, 0, 0);
        tbl[3]  = mk(1, 2, 0, 0, 0);
        tbl[4]  = mk(1, 3, 1, 0, 0);
        tbl[5]  = mk(1, 0, 0, 1, 0);
        tbl[6]  = mk(1, 1, 0, 0, 0);
        tbl[7]  = mk(1, 2, 0, 0, 0);
        tbl[8]  = mk(1, 3, 1, 0, 0);
        tbl[9]  = mk(1, 0, 0, 1, 1);
        tbl[10] = mk(1, 1, 0, 0, 0);
        tbl[11] = mk(1, 2, 0, 0, 0);
        tbl[12] = mk(0, 3, 1, 0, 0);
        tbl[13] = mk(0, 0, 0, 1, 1);
        tbl[14] = mk(0, 0, 0, 0, 0);
        tbl[15] = mk(0, 0, 0, 0, 0);
        tbl[16] = mk(0, 0, 0, 0, 0);
        tbl[17] = mk(0, 0, 0, 0, 1);
        tbl[18] = mk(0, 0, 0, 0, 0);

        repeat (3) step();
        reset = 1'b0;
        chk("rst_phase", int'(ph), 0);
        chk("rst_sam", int'(sam), 0);
        chk("rst_clr", int'(clr), 0);
        chk("rst_yv", int'(yv), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_bank", int'(bsel), 0);
        chk("rst_ready", int'(rdy), 1);

        // Streaming: run held for 12 cycles.
        for (int i = 0; i < 19; i++) begin
            run = tbl[i].run;
            chk($sformatf("t1_phase_c%0d", i), int'(ph), int'(tbl[i].ph));
            chk($sformatf("t1_sam_c%0d", i), int'(sam), int'(tbl[i].sam));
            chk($sformatf("t1_clr_c%0d", i), int'(clr), int'(tbl[i].clr));
            chk($sformatf("t1_yv_c%0d", i), int'(yv), int'(tbl[i].yv));
            step();
        end

        // Load bank 1 with k+1 and commit while idle.
        for (int k = 0; k < NT; k++) wr(k, k + 1);
        commit_idle();
        run_sample();
        repeat (10) step();

        // Load bank 0 with 100+k and commit mid-sample at phase 1.
        for (int k = 0; k < NT; k++) wr(k, 100 + k);
        run = 1'b1;
        step();
        chk_coef(0);
        step();
        cfg_commit = 1'b1;
        chk("t3_ready_p1", int'(rdy), 1);
        step();
        cfg_commit = 1'b0;
        chk("t3_ready_p2", int'(rdy), 0);
        chk("t3_bank_p2", int'(bsel), 1);
        step();
        chk("t3_sam_p3", int'(sam), 1);
        chk("t3_ready_p3", int'(rdy), 0);
        chk("t3_bank_p3", int'(bsel), 1);
        step();
        eb = 0;
        chk("t3_ready_new", int'(rdy), 1);
        chk("t3_bank_new", int'(bsel), 0);
        chk("t3_phase_new", int'(ph), 0);
        chk_coef(0);
        run = 1'b0;
        step();
        step();
        chk_coef(2);
        step();
        step();
        chk("t3_idle", int'(ph), 0);
        repeat (10) step();

        // Out-of-range writes are dropped and flagged; in-range write lands.
        wr(51, 5);
        wr(63, 7);
        wr(50, 777);
        step();
        chk("err_clear", int'(err), 0);
        commit_idle();
        run_sample();
        repeat (10) step();

        // Drop run at phase 1: drain, one strobe, final y_valid still arrives.
        run = 1'b1;
        step();
        for (int c = 1; c <= 12; c++) begin
            if (c == 2) run = 1'b0;
            chk($sformatf("t5_phase_c%0d", c), int'(ph), c <= 4 ? c - 1 : 0);
            chk($sformatf("t5_sam_c%0d", c), int'(sam), c == 4 ? 1 : 0);
            chk($sformatf("t5_clr_c%0d", c), int'(clr), c == 5 ? 1 : 0);
            chk($sformatf("t5_yv_c%0d", c), int'(yv), c == 9 ? 1 : 0);
            step();
        end

        // Reset at phase 2 with a swap pending flushes everything.
        run = 1'b1;
        step();
        step();
        cfg_commit = 1'b1;
        step();
        cfg_commit = 1'b0;
        chk("t6_phase", int'(ph), 2);
        chk("t6_pend", int'(rdy), 0);
        reset = 1'b1;
        run = 1'b0;
        step();
        reset = 1'b0;
        chk("t6_bank", int'(bsel), 0);
        chk("t6_ready", int'(rdy), 1);
        chk("t6_phase0", int'(ph), 0);
        chk("t6_err", int'(err), 0);
        for (int c = 0; c < 12; c++) begin
            chk($sformatf("t6_clr_c%0d", c), int'(clr), 0);
            chk($sformatf("t6_yv_c%0d", c), int'(yv), 0);
            chk($sformatf("t6_sam_c%0d", c), int'(sam), 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
